keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad by driving one column low at a time and reading the row lines through the existing 4-bit `synchronizer`. It debounces each press and release, and reports one registered key code per physical press. The block sits between the keypad pins and the key-history/display logic. It is the only owner of the column drive and of the row synchronizer.

## Interface

Parameters:
- `SCAN_CYCLES`, default 1200: clocks each column is driven during scan; minimum 4.
- `DEBOUNCE_CYCLES`, default 240000: clocks a row pattern must stay stable to accept a press or a release; minimum 1.

Ports:
- `clk`, input, 1: system clock.
- `reset`, input, 1: synchronous, active-high reset.
- `rows`, input, 4: raw row pins, active-low, pulled up externally; asynchronous.
- `cols`, output, 4: column drive, one-hot active-low.
- `key_code`, output, 4: `{row_idx[1:0], col_idx[1:0]}` of the accepted key; holds its value until the next accept.
- `key_valid`, output, 1: single-cycle pulse when a press is accepted.
- `key_held`, output, 1: high from accept until the release is debounced.

## Operation

- `rows` passes through the `synchronizer` sub-module (2-flop, reset to 0) to give `rows_s`. Only `rows_s` is used internally.
- Internal registers:
  - `col_idx` (2 bits).
  - `cnt`: width `$clog2(max(SCAN_CYCLES, DEBOUNCE_CYCLES))`.
  - `row_idx` (2 bits).
  - `pattern` (4 bits).
  - `state`.
- `cols` is always `~(4'b1 << col_idx)`.
- **SCAN**
  - `cnt` increments each cycle.
  - If `cnt >= SETTLE_CYCLES` and `rows_s != 4'hF`:
    - `pattern <= rows_s`.
    - `row_idx <=` lowest-index zero bit of `rows_s`.
    - `cnt <= 0`; go to DB_PRESS.
  - Otherwise, when `cnt == SCAN_CYCLES-1`: `col_idx <= col_idx+1` (3 wraps to 0), `cnt <= 0`.
- **DB_PRESS**
  - Column is held.
  - If `rows_s != pattern`: go to SCAN with `col_idx+1` and `cnt=0` (bounce rejected).
  - Else, when `cnt == DEBOUNCE_CYCLES-1`: `key_code <= {row_idx, col_idx}`, pulse `key_valid`, set `key_held`, go to HELD.
  - Else `cnt++`.
- **HELD**
  - Column is held; `cnt=0`.
  - When `rows_s[row_idx]==1`: go to DB_REL.
  - Other rows going low are ignored: one key at a time, no rollover.
- **DB_REL**
  - If `rows_s[row_idx]==0`: return to HELD with `cnt=0`.
  - When `cnt == DEBOUNCE_CYCLES-1`: clear `key_held`, `col_idx+1`, `cnt=0`, go to SCAN.
  - Else `cnt++`.
- **Multiple rows low at detection:** the lowest row index wins. Any change of the pattern during DB_PRESS restarts scanning.
- **Reset values:**
  - State: `state=SCAN`, `col_idx=0`, `cnt=0`.
  - Outputs: `cols=4'b1110`, `key_code=4'h0`, `key_valid=0`, `key_held=0`.
  - Synchronizer flops: 0.
- **Reset mid-operation:** any state returns to the reset values on the next edge. No `key_valid` is emitted for a key already in debounce. A key still physically held after reset is detected again as a new press.

## Timing

- Synchronizer latency: 2 clocks from `rows` to `rows_s`.
- `SETTLE_CYCLES = 3`: rows are ignored for the first 3 scan cycles after a column change (synchronizer latency plus 1 cycle margin).
- Press latency, measured from the edge that enters DB_PRESS: `key_valid` is high in the cycle after edge `DEBOUNCE_CYCLES`.
- `key_valid`, `key_code` and `key_held` change on the same edge.
- `key_valid` is exactly 1 cycle wide. It never reasserts until `key_held` has fallen and a new press is accepted.
- Release latency: `key_held` falls `DEBOUNCE_CYCLES` clocks after entering DB_REL with no bounce.
- Worst-case detection delay without debounce: `4*SCAN_CYCLES + 2` clocks.
- All outputs are registered; there are no combinational paths from `rows` to outputs.

## Structure

- Package `keypad_pkg`:
  - `typedef enum logic [1:0] {SCAN, DB_PRESS, HELD, DB_REL} keypad_state_t`.
  - `localparam SETTLE_CYCLES = 3`.
- One sub-module: the existing `synchronizer` (4 bits wide), instantiated as `u_sync`.
- The FSM, counter and output registers live in `keypad_scanner`.

## Test plan

All scenarios use `SCAN_CYCLES=8`, `DEBOUNCE_CYCLES=4`.

1. **Idle after reset:** reset high for 2 cycles, then `rows=4'hF` for 64 cycles.
   - `cols` steps 1110→1101→1011→0111→1110, each lasting 8 cycles.
   - `key_valid` never rises; `key_code=0`.
2. **Clean press:** `rows=4'b1101` only while `cols==4'b1011`, held 40 cycles, then released.
   - One `key_valid` pulse with `key_code=4'b0110`.
   - `key_held` high until 4 cycles after `rows_s` returns high.
   - Scan then resumes at `cols=0111`.
3. **Bounce rejection:** the row toggles low/high every 2 cycles during DB_PRESS.
   - No `key_valid`; scanning advances to the next column.
   - A steady press afterwards yields exactly one `key_valid`.
4. **Release bounce:** during DB_REL the row returns low for 2 cycles.
   - `key_held` stays high and no second `key_valid` occurs.
   - The final clean release clears `key_held` after 4 stable cycles.
5. **Two keys:** `rows=4'b1010` on column 0.
   - `key_code=4'b0000` (row 0 wins).
   - Pressing a different column's key while HELD produces no pulse.
6. **Reset mid-debounce:** assert reset for 1 cycle in DB_PRESS.
   - Next cycle: `cols=1110`, `key_valid=0`, `key_held=0`, `state=SCAN`.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the matrix keypad scanner.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DB_PRESS = 2'd1,
        HELD     = 2'd2,
        DB_REL   = 2'd3
    } keypad_state_t;

    // Scan cycles ignored after a column change: two synchronizer stages
    // plus one cycle of margin for the row lines to settle.
    localparam int SETTLE_CYCLES = 3;

    // Index of the lowest active-low row; row 0 wins when several are low.
    function automatic logic [1:0] lowest_zero(input logic [3:0] r);
        logic [1:0] idx;
        if (!r[0]) begin
            idx = 2'd0;
        end else if (!r[1]) begin
            idx = 2'd1;
        end else if (!r[2]) begin
            idx = 2'd2;
        end else begin
            idx = 2'd3;
        end
        return idx;
    endfunction

endpackage

// File: rtl/synchronizer.sv
// Two-flop synchronizer for asynchronous multi-bit level inputs.
module synchronizer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Both stages clear to zero on reset; each bit is synchronized independently.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            always_ff @(posedge clk) begin
                if (reset) begin
                    meta[gi] <= 1'b0;
                    q[gi]    <= 1'b0;
                end else begin
                    meta[gi] <= d[gi];
                    q[gi]    <= meta[gi];
                end
            end
        end
    endgenerate

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: walks the columns low one at a time,
// debounces press and release, and reports one key code per press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_CYCLES     = 1200,
    parameter int DEBOUNCE_CYCLES = 240000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int CNT_MAX = (SCAN_CYCLES > DEBOUNCE_CYCLES) ? SCAN_CYCLES : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_LAST   = CNT_W'(SCAN_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE      = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic [3:0]       rows_s;
    logic [1:0]       col_idx;
    logic [1:0]       row_idx;
    logic [3:0]       pattern;
    logic [CNT_W-1:0] cnt;
    keypad_state_t    state;

    synchronizer #(
        .WIDTH(4)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (rows),
        .q    (rows_s)
    );

    // Column drive follows col_idx directly, so it only changes on clock edges.
    assign cols = ~(4'b0001 << col_idx);

    // Scan / debounce state machine with its counter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= SCAN;
            col_idx   <= 2'd0;
            row_idx   <= 2'd0;
            pattern   <= 4'hF;
            cnt       <= '0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                SCAN: begin
                    if (cnt >= SETTLE && rows_s != 4'hF) begin
                        pattern <= rows_s;
                        row_idx <= lowest_zero(rows_s);
                        cnt     <= '0;
                        state   <= DB_PRESS;
                    end else if (cnt == SCAN_LAST) begin
                        col_idx <= col_idx + 2'd1;
                        cnt     <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DB_PRESS: begin
                    // Any change of the captured pattern counts as bounce.
                    if (rows_s != pattern) begin
                        col_idx <= col_idx + 2'd1;
                        cnt     <= '0;
                        state   <= SCAN;
                    end else if (cnt == DB_LAST) begin
                        key_code  <= {row_idx, col_idx};
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                        cnt       <= '0;
                        state     <= HELD;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                HELD: begin
                    // Only the accepted row matters; no rollover to other keys.
                    cnt <= '0;
                    if (rows_s[row_idx]) begin
                        state <= DB_REL;
                    end
                end
                DB_REL: begin
                    if (!rows_s[row_idx]) begin
                        cnt   <= '0;
                        state <= HELD;
                    end else if (cnt == DB_LAST) begin
                        key_held <= 1'b0;
                        col_idx  <= col_idx + 2'd1;
                        cnt      <= '0;
                        state    <= SCAN;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= SCAN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple physical keypad model.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // pressed[r][c]: key at row r, column c is physically down.
    logic [3:0][3:0] pressed;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [3:0] last_code = 4'h0;

    keypad_scanner #(
        .SCAN_CYCLES    (8),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rows     (rows),
        .cols     (cols),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    // A pressed key pulls its row low while its column is driven low.
    always_comb begin
        rows = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r][c] && !cols[c]) begin
                    rows[r] = 1'b0;
                end
            end
        end
    end

    // Advance one clock and sample 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) begin
            vcount++;
            last_code = key_code;
        end
    endtask

    // Wait for a fresh entry into the given column (cnt just cleared).
    task automatic wait_col(input logic [3:0] target);
        int n;
        n = 0;
        while (cols === target && n < 100) begin
            step();
            n++;
        end
        while (cols !== target && n < 100) begin
            step();
            n++;
        end
        checks++;
        if (cols !== target) begin
            errors++;
            $display("FAIL wait_col: got %b expected %b within 100 cycles", cols, target);
        end
    endtask

    task automatic wait_valid(input int bound);
        int n;
        int start;
        n = 0;
        start = vcount;
        while (vcount == start && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (vcount == start) begin
            errors++;
            $display("FAIL wait_valid: no key_valid within %0d cycles", bound);
        end
    endtask

    task automatic wait_held_low(input int bound);
        int n;
        n = 0;
        while (key_held !== 1'b0 && n < bound) begin
            step();
            n++;
        end
        checks++;
        if (key_held !== 1'b0) begin
            errors++;
            $display("FAIL wait_held_low: key_held=%b after %0d cycles", key_held, bound);
        end
    endtask

    task automatic test_reset();
        pressed = '0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        checks++;
        if (cols !== 4'b1110) begin
            errors++;
            $display("FAIL reset_cols: got %b expected 1110", cols);
        end
        checks++;
        if (key_code !== 4'h0 || key_valid !== 1'b0 || key_held !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got code=%h valid=%b held=%b expected 0/0/0",
                     key_code, key_valid, key_held);
        end
        $display("test_reset done");
    endtask

    task automatic test_idle();
        logic [3:0] one;
        logic [3:0] exp_cols;
        int bad;
        int start;
        bad = 0;
        start = vcount;
        one = 4'b0001;
        for (int i = 0; i < 64; i++) begin
            exp_cols = ~(one << ((i / 8) % 4));
            if (cols !== exp_cols && bad == 0) begin
                bad = 1;
                $display("FAIL idle_cols: sample %0d got %b expected %b", i, cols, exp_cols);
            end
            step();
        end
        checks++;
        if (bad != 0) errors++;
        checks++;
        if (vcount != start || key_code !== 4'h0) begin
            errors++;
            $display("FAIL idle_valid: got pulses=%0d code=%h expected 0/0", vcount - start, key_code);
        end
        $display("test_idle done");
    endtask

    task automatic test_clean_press();
        int start;
        wait_col(4'b1011);
        start = vcount;
        pressed[1][2] = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            step();
            if (i == 7 || i == 9) begin
                checks++;
                if (key_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL press_edge: step %0d key_valid=%b expected 0", i, key_valid);
                end
            end
            if (i == 8) begin
                checks++;
                if (key_valid !== 1'b1 || key_code !== 4'b0110 || key_held !== 1'b1) begin
                    errors++;
                    $display("FAIL press_accept: got valid=%b code=%b held=%b expected 1/0110/1",
                             key_valid, key_code, key_held);
                end
            end
        end
        checks++;
        if (vcount - start != 1) begin
            errors++;
            $display("FAIL press_pulses: got %0d expected 1", vcount - start);
        end
        pressed[1][2] = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            step();
            checks++;
            if (key_held !== (i < 7)) begin
                errors++;
                $display("FAIL release_held: step %0d got %b expected %b", i, key_held, (i < 7));
            end
        end
        checks++;
        if (cols !== 4'b0111) begin
            errors++;
            $display("FAIL release_resume: got %b expected 0111", cols);
        end
        $display("test_clean_press done code=%b", last_code);
    endtask

    task automatic test_bounce();
        int start;
        wait_col(4'b0111);
        start = vcount;
        pressed[2][3] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 4 || i == 8) pressed[2][3] = 1'b0;
            if (i == 6 || i == 10) pressed[2][3] = 1'b1;
            if (i == 7) begin
                checks++;
                if (cols !== 4'b1110) begin
                    errors++;
                    $display("FAIL bounce_advance: got %b expected 1110", cols);
                end
            end
        end
        checks++;
        if (vcount != start) begin
            errors++;
            $display("FAIL bounce_pulses: got %0d expected 0", vcount - start);
        end
        for (int i = 0; i < 70; i++) step();
        checks++;
        if (vcount - start != 1 || last_code !== 4'b1011) begin
            errors++;
            $display("FAIL bounce_steady: got pulses=%0d code=%b expected 1/1011",
                     vcount - start, last_code);
        end
        pressed[2][3] = 1'b0;
        wait_held_low(20);
        $display("test_bounce done");
    endtask

    task automatic test_release_bounce();
        int start;
        wait_col(4'b1101);
        pressed[3][1] = 1'b1;
        wait_valid(20);
        checks++;
        if (key_code !== 4'b1101) begin
            errors++;
            $display("FAIL relbounce_code: got %b expected 1101", key_code);
        end
        start = vcount;
        step();
        step();
        step();
        pressed[3][1] = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            if (i == 3) pressed[3][1] = 1'b1;
            if (i == 5) pressed[3][1] = 1'b0;
            checks++;
            if (key_held !== (i < 12)) begin
                errors++;
                $display("FAIL relbounce_held: step %0d got %b expected %b", i, key_held, (i < 12));
            end
        end
        checks++;
        if (vcount != start || cols !== 4'b1011) begin
            errors++;
            $display("FAIL relbounce_after: got pulses=%0d cols=%b expected 0/1011",
                     vcount - start, cols);
        end
        $display("test_release_bounce done");
    endtask

    task automatic test_two_keys();
        int start;
        wait_col(4'b1110);
        pressed[0][0] = 1'b1;
        pressed[2][0] = 1'b1;
        wait_valid(20);
        checks++;
        if (key_code !== 4'b0000 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL two_keys_code: got code=%b held=%b expected 0000/1", key_code, key_held);
        end
        start = vcount;
        pressed[1][2] = 1'b1;
        pressed[1][0] = 1'b1;
        for (int i = 0; i < 20; i++) step();
        checks++;
        if (vcount != start || key_held !== 1'b1 || cols !== 4'b1110) begin
            errors++;
            $display("FAIL two_keys_held: got pulses=%0d held=%b cols=%b expected 0/1/1110",
                     vcount - start, key_held, cols);
        end
        pressed = '0;
        wait_held_low(30);
        $display("test_two_keys done");
    endtask

    task automatic test_reset_mid();
        int start;
        wait_col(4'b1101);
        pressed[0][1] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (cols !== 4'b1110 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
            errors++;
            $display("FAIL reset_mid: got cols=%b valid=%b held=%b code=%h expected 1110/0/0/0",
                     cols, key_valid, key_held, key_code);
        end
        start = vcount;
        for (int i = 0; i < 40; i++) step();
        checks++;
        if (vcount - start != 1 || last_code !== 4'b0001 || key_held !== 1'b1) begin
            errors++;
            $display("FAIL reset_redetect: got pulses=%0d code=%b held=%b expected 1/0001/1",
                     vcount - start, last_code, key_held);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (key_held !== 1'b0 || key_code !== 4'h0 || cols !== 4'b1110) begin
            errors++;
            $display("FAIL reset_held: got held=%b code=%h cols=%b expected 0/0/1110",
                     key_held, key_code, cols);
        end
        pressed = '0;
        step();
        $display("test_reset_mid done");
    endtask

    initial begin
        reset = 1'b0;
        pressed = '0;
        test_reset();
        test_idle();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_two_keys();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
